pressure_scan_scheduler: RTL
============================

Name: pressure_scan_scheduler

Overview:
Time-shares one pressureAbnormalityDetector instance across NUM_CH 6-bit pressure channels. The block scans the channels round-robin, presents each sample to the detector and captures its abnormality verdict. It debounces each channel with a consecutive-abnormal counter and raises sticky per-channel alarms. It sits between the pressure sensor registers and the alarm/display logic.

Parameters:
NUM_CH, 4, number of pressure channels scanned (2..8)
THRESH, 3, consecutive abnormal samples needed to raise a channel alarm (1..15)
SCAN_GAP, 2, idle cycles between consecutive scans (0..255)

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  synchronous reset, active-low
scan_en  in  1  level; 1 = keep scanning, 0 = stop after the current scan
ch_data  in  NUM_CH*6  packed channel samples; channel k = bits [6k+5:6k]
det_data  out  6  drives pressureData of the shared detector
det_abnormal  in  1  presureAbnormality returned by the detector (combinational)
alarm_ack  in  NUM_CH  per-channel alarm clear request
alarm  out  NUM_CH  sticky per-channel alarm
alarm_any  out  1  OR of alarm
cur_ch  out  clog2(NUM_CH)  channel currently driven
scan_done  out  1  one-cycle pulse at the end of each full scan

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; alarm=0; all counters=0; cur_ch=0; det_data=0; scan_done=0.
  - Reset applies mid-scan with no partial update of counters or alarms.
- States and transitions:
  - IDLE: det_data=0. Goes to DRIVE with cur_ch=0 when scan_en=1.
  - DRIVE: det_data=ch_data[cur_ch] (registered); one cycle for the detector to settle; then SAMPLE.
  - SAMPLE: det_data held; det_abnormal captured into cnt[cur_ch].
    - If cur_ch<NUM_CH-1: cur_ch+1, then DRIVE.
    - Else: DONE.
  - DONE: scan_done=1 for this cycle only. cur_ch returns to 0.
    - scan_en=1 and SCAN_GAP>0: go to WAIT.
    - scan_en=1 and SCAN_GAP=0: go to DRIVE.
    - scan_en=0: go to IDLE.
  - WAIT: det_data=0. Counts SCAN_GAP cycles, then DRIVE. If scan_en drops during WAIT, go to IDLE immediately.
- Timing:
  - Per channel: 2 cycles.
  - Full scan: 2*NUM_CH+1 cycles (DONE included) plus SCAN_GAP.
  - Dropping scan_en during DRIVE or SAMPLE does not abort; the scan completes first.
- Counter update in SAMPLE, per channel, width clog2(THRESH+1):
  - det_abnormal=1: cnt = min(cnt+1, THRESH); saturates, never wraps.
  - det_abnormal=0: cnt = 0.
- Alarm set/clear:
  - alarm[k] sets in the same cycle cnt[k] becomes THRESH (registered; visible the cycle after SAMPLE).
  - alarm[k] stays set while cnt[k] remains at THRESH.
  - alarm_ack[k]=1 clears alarm[k] only if cnt[k]<THRESH at that edge; otherwise the ack is ignored. Ack is not remembered.
  - Set and ack in the same cycle: set wins.
  - Ack is honoured in any state, including IDLE and WAIT.
- alarm_any is combinational OR of registered alarm.
- ch_data is sampled only in DRIVE. Changes at other times have no effect until that channel is driven again.

Optional Feature:
Macro CHANNEL_MASK_EN.
- Defined:
  - Adds input port ch_mask (NUM_CH bits).
  - A channel with ch_mask[k]=1 is skipped entirely: no DRIVE/SAMPLE cycles, cnt[k] forced to 0, alarm[k] forced to 0.
  - Scan length = 2*(unmasked count)+1 cycles.
  - All channels masked: DRIVE/SAMPLE are skipped and each scan is DONE only.
- Undefined: no ch_mask port; all NUM_CH channels are always scanned.

Test Plan:
- Reset with rst_n=0 held for 3 cycles, then released -> alarm=0, alarm_any=0, det_data=0, cur_ch=0, scan_done=0. Reassert rst_n mid-scan (ch2 SAMPLE) -> next cycle state=IDLE, counters=0.
- scan_en=1, channels 10/20/30/40, detector model flags values >35 -> det_data sequence 10,10,20,20,30,30,40,40. scan_done pulses 9 cycles after first DRIVE, then 2 WAIT cycles, then DRIVE ch0 again.
- ch3=50 held abnormal (NUM_CH=4, THRESH=3, SCAN_GAP=2) -> alarm[3]=1 after the 3rd ch3 SAMPLE, at cycle 3*11-3 from scan start. Ch3 normal on the 2nd scan -> counter resets and no alarm until 3 more consecutive abnormal samples.
- alarm[3]=1 and ch3 still abnormal, alarm_ack[3]=1 -> alarm stays 1. Set ch3=20, wait one scan, pulse ack -> alarm[3]=0 and alarm_any=0. Ack coinciding with the setting SAMPLE -> alarm=1.
- Drop scan_en during ch1 DRIVE -> scan completes through ch3, scan_done pulses, state=IDLE, det_data=0. Drop scan_en during WAIT -> IDLE next cycle with no further DRIVE.
- With CHANNEL_MASK_EN, ch_mask=4'b0101 -> only ch1 and ch3 are driven; scan length 5 cycles; alarm[0] and alarm[2] stay 0 even when ch0=63.

Source files
------------

// File: rtl/pressure_scan_scheduler_if.sv
// Signal bundle between pressure_scan_scheduler (master) and its surroundings (slave).
// With CHANNEL_MASK_EN defined the bundle also carries ch_mask.
interface pressure_scan_scheduler_if #(
    parameter int NUM_CH = 4
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                  scan_en;
    logic [NUM_CH*6-1:0]   ch_data;
    logic [5:0]            det_data;
    logic                  det_abnormal;
    logic [NUM_CH-1:0]     alarm_ack;
    logic [NUM_CH-1:0]     alarm;
    logic                  alarm_any;
    logic [CH_W-1:0]       cur_ch;
    logic                  scan_done;
`ifdef CHANNEL_MASK_EN
    logic [NUM_CH-1:0]     ch_mask;
`endif

    modport master (
`ifdef CHANNEL_MASK_EN
        input  ch_mask,
`endif
        input  scan_en, ch_data, det_abnormal, alarm_ack,
        output det_data, alarm, alarm_any, cur_ch, scan_done
    );

    modport slave (
`ifdef CHANNEL_MASK_EN
        output ch_mask,
`endif
        output scan_en, ch_data, det_abnormal, alarm_ack,
        input  det_data, alarm, alarm_any, cur_ch, scan_done
    );
endinterface

// File: rtl/pressure_scan_scheduler.sv
// Round-robin scan of NUM_CH pressure channels through one shared abnormality detector,
// with per-channel debounce counters and sticky alarms. CHANNEL_MASK_EN adds per-channel skip.
//
// state  | meaning
// IDLE   | not scanning, det_data parked at 0
// DRIVE  | det_data holds the current channel, detector settling
// SAMPLE | detector verdict folded into the channel counter
// DONE   | one-cycle end-of-scan marker
// WAIT   | SCAN_GAP idle cycles before the next scan
module pressure_scan_scheduler #(
    parameter int NUM_CH   = 4,
    parameter int THRESH   = 3,
    parameter int SCAN_GAP = 2
) (
    input logic                       clk,
    input logic                       rst_n,
    pressure_scan_scheduler_if.master bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(THRESH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(THRESH);
    localparam logic [7:0]       GAP_LOAD = (SCAN_GAP > 0) ? 8'(SCAN_GAP - 1) : 8'd0;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DRIVE  = 3'd1;
    localparam logic [2:0] SAMPLE = 3'd2;
    localparam logic [2:0] DONE   = 3'd3;
    localparam logic [2:0] WAIT   = 3'd4;

    logic [2:0]        state, stateNxt;
    logic [CH_W-1:0]   curCh, chNxt, firstCh, nextCh;
    logic              firstVld, nextVld;
    logic [7:0]        gapCnt, gapNxt;
    logic [5:0]        detData;
    logic [NUM_CH-1:0] alarmReg, chMask, sampleHit, setHit;
    logic [CNT_W-1:0]  cnt    [NUM_CH];
    logic [CNT_W-1:0]  cntUpd [NUM_CH];
    logic [5:0]        chArr  [NUM_CH];

`ifdef CHANNEL_MASK_EN
    assign chMask = bus.ch_mask;
`else
    assign chMask = '0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign chArr[g] = bus.ch_data[6*g +: 6];
    end

    // Lowest unmasked channel overall, and lowest unmasked channel above curCh.
    always_comb begin
        firstCh  = '0;
        firstVld = 1'b0;
        nextCh   = '0;
        nextVld  = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (!chMask[k]) begin
                firstCh  = CH_W'(k);
                firstVld = 1'b1;
                if (CH_W'(k) > curCh) begin
                    nextCh  = CH_W'(k);
                    nextVld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        stateNxt = state;
        chNxt    = curCh;
        gapNxt   = gapCnt;
        case (state)
            IDLE: begin
                if (bus.scan_en) begin
                    stateNxt = firstVld ? DRIVE : DONE;
                    chNxt    = firstCh;
                end
            end
            DRIVE: stateNxt = SAMPLE;
            SAMPLE: begin
                if (nextVld) begin
                    stateNxt = DRIVE;
                    chNxt    = nextCh;
                end else begin
                    stateNxt = DONE;
                    chNxt    = '0;
                end
            end
            DONE: begin
                if (!bus.scan_en) begin
                    stateNxt = IDLE;
                end else if (SCAN_GAP > 0) begin
                    stateNxt = WAIT;
                    gapNxt   = GAP_LOAD;
                end else begin
                    stateNxt = firstVld ? DRIVE : DONE;
                    chNxt    = firstCh;
                end
            end
            WAIT: begin
                if (!bus.scan_en) begin
                    stateNxt = IDLE;
                end else if (gapCnt == 8'd0) begin
                    stateNxt = firstVld ? DRIVE : DONE;
                    chNxt    = firstCh;
                end else begin
                    gapNxt = gapCnt - 8'd1;
                end
            end
            default: begin
                stateNxt = IDLE;
                chNxt    = '0;
            end
        endcase
    end

    // Saturating debounce count and alarm-set condition for the channel being sampled.
    always_comb begin
        sampleHit = '0;
        setHit    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sampleHit[k] = (state == SAMPLE) && (curCh == CH_W'(k));
            if (!bus.det_abnormal)
                cntUpd[k] = '0;
            else if (cnt[k] == CNT_MAX)
                cntUpd[k] = CNT_MAX;
            else
                cntUpd[k] = cnt[k] + CNT_W'(1);
            setHit[k] = sampleHit[k] && (cntUpd[k] == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            curCh    <= '0;
            gapCnt   <= '0;
            detData  <= '0;
            alarmReg <= '0;
            for (int k = 0; k < NUM_CH; k++)
                cnt[k] <= '0;
        end else begin
            state  <= stateNxt;
            curCh  <= chNxt;
            gapCnt <= gapNxt;
            // Loading on entry to DRIVE gives the detector the whole DRIVE cycle to settle.
            if (stateNxt == DRIVE)
                detData <= chArr[chNxt];
            else if (stateNxt != SAMPLE)
                detData <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                if (chMask[k]) begin
                    cnt[k]      <= '0;
                    alarmReg[k] <= 1'b0;
                end else begin
                    if (sampleHit[k])
                        cnt[k] <= cntUpd[k];
                    if (setHit[k])
                        alarmReg[k] <= 1'b1;
                    else if (bus.alarm_ack[k] && (cnt[k] < CNT_MAX))
                        alarmReg[k] <= 1'b0;
                end
            end
        end
    end

    assign bus.det_data  = detData;
    assign bus.alarm     = alarmReg;
    assign bus.alarm_any = |alarmReg;
    assign bus.cur_ch    = curCh;
    assign bus.scan_done = (state == DONE);
endmodule
